mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Responder side of the instruction-fetch memory handshake. Also serves the load/store buffer.
//  Arbitrates between the two requesters and runs byte-serial accesses on the 8-bit RAM/IO bus.
//  Assembles little-endian words for reads and returns each result with a one-cycle ok pulse.
//  Sits between ifetcher/lsb and the external RAM port.
// PARAMETERS
//  ADDR_W   32     width of request addresses and mem_a
//  IO_HI    2'b11  value of addr[17:16] that selects the IO region
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst             in   1   reset, asynchronous, active-high
//  rdy             in   1   global enable; when 0 all state and outputs hold
//  from_if_ready   in   1   fetch request; held high by ifetcher until to_if_ok
//  from_if_addr    in   32  fetch address (word aligned)
//  to_if_ok        out  1   one-cycle pulse, to_if_data valid
//  to_if_data      out  32  fetched instruction word
//  from_lsb_ready  in   1   load/store request, held until to_lsb_ok
//  from_lsb_wr     in   1   1 = store, 0 = load
//  from_lsb_len    in   2   00 byte, 01 half, 10 word (11 treated as word)
//  from_lsb_addr   in   32  access address
//  from_lsb_data   in   32  store data, low bytes used
//  to_lsb_ok       out  1   one-cycle pulse, load data valid / store done
//  to_lsb_data     out  32  load data, zero-extended
//  from_rob_clear  in   1   pipeline flush
//  io_buffer_full  in   1   IO write buffer full
//  mem_din         in   8   RAM read data, valid one cycle after mem_a presented
//  mem_dout        out  8   RAM write byte
//  mem_a           out  32  RAM address
//  mem_wr          out  1   1 = write
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs 0.
//  States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
//  IDLE accepts at most one request per edge. from_lsb_ready has fixed priority over from_if_ready.
//  The accepted addr/len/data are latched. N = 1/2/4 bytes (fetch always 4).
//  Read, request sampled at edge E0:
//   - mem_a = addr+k driven after edge Ek, for k = 0..N-1.
//   - byte k is captured from mem_din at edge E(k+2) into bits [8k+7:8k].
//   - ok and data are registered at edge E(N+1), then the FSM goes to DONE.
//   - Word fetch: to_if_ok is high in the cycle after E5.
//  Write, request sampled at E0:
//   - mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] after edge Ek, k = 0..N-1.
//   - mem_wr drops at E(N); to_lsb_ok pulses after E(N).
//  IO stores (addr[17:16]==IO_HI) are not accepted while io_buffer_full=1.
//   - Once started, a store never stalls.
//  DONE: ok deasserts and the bus is idle (mem_wr=0, mem_a=0). Return to IDLE next edge.
//   - This one-cycle gap lets the requester drop ready, so no request is served twice.
//  ok outputs are high for exactly one cycle. Data outputs hold until the next ok.
//  Address arithmetic is modulo 2^32. addr+k wraps, and no alignment check is made.
//  from_rob_clear=1 at an edge:
//   - An in-flight IF_RD or LS_RD aborts to IDLE with no ok pulse and mem_wr=0.
//   - An in-flight LS_WR completes and pulses ok, because committed stores are never lost.
//   - No new request is accepted at that edge.
//  A clear in the same cycle as a read's completing edge suppresses that ok.
//  rdy=0 freezes cnt/state/outputs. Bus outputs keep their values.
//  Reset mid-access aborts immediately. Outputs go to reset values asynchronously.
// STRUCTURE
//  mem_ctrl_pkg: state encodings, LEN_BYTE/LEN_HALF/LEN_WORD, IO_HI.
//  Single module with no sub-module. Datapath = 2-bit byte counter + 32-bit shift/assemble register.
// TESTING
//  1 Fetch 0x0000_0004, RAM bytes 13 05 00 00
//    -> to_if_ok one cycle after E5, data 0x0000_0513, then 1 idle cycle.
//  2 LSB load half 0x100 (bytes AB CD) together with IF request
//    -> LSB served first: to_lsb_data=0x0000_CDAB after E3; IF accepted after DONE.
//  3 Store word 0xDEADBEEF at 0x200
//    -> mem_wr for 4 cycles with bytes EF BE AD DE at 0x200..0x203; ok after E4.
//  4 Store byte to 0x30000 with io_buffer_full=1 for 3 cycles
//    -> no mem_wr until full drops; then 1 write cycle and an ok pulse.
//  5 from_rob_clear during word fetch at E2 -> no to_if_ok, FSM in IDLE, next fetch is clean.
//  6 rdy=0 for 2 cycles mid-load, and separately rst asserted mid-store
//    -> rdy: latency extends by 2 cycles, data is correct; rst: all outputs 0 immediately.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [1:0] IO_HI    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_LS_RD,
    ST_LS_WR,
    ST_DONE
  } state_e;

  // Index of the final byte of an access; the reserved encoding acts as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      LEN_BYTE: last_idx = 2'd0;
      LEN_HALF: last_idx = 2'd1;
      default:  last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto the 8-bit RAM bus, running
// byte-serial accesses and returning little-endian words with a one-cycle ok.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = mem_ctrl_pkg::IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              from_if_ready,
  input  logic [ADDR_W-1:0] from_if_addr,
  output logic              to_if_ok,
  output logic [DATA_W-1:0] to_if_data,
  input  logic              from_lsb_ready,
  input  logic              from_lsb_wr,
  input  logic [1:0]        from_lsb_len,
  input  logic [ADDR_W-1:0] from_lsb_addr,
  input  logic [DATA_W-1:0] from_lsb_data,
  output logic              to_lsb_ok,
  output logic [DATA_W-1:0] to_lsb_data,
  input  logic              from_rob_clear,
  input  logic              io_buffer_full,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic                skip_q, skip_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                to_if_ok_q, to_if_ok_d;
  logic [DATA_W-1:0]   to_if_data_q, to_if_data_d;
  logic                to_lsb_ok_q, to_lsb_ok_d;
  logic [DATA_W-1:0]   to_lsb_data_q, to_lsb_data_d;
  logic [BYTE_W-1:0]   mem_dout_q, mem_dout_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic                mem_wr_q, mem_wr_d;
  logic [1:0]          nxt_cnt;
  logic                lsb_go;

  // An IO store is held off while the IO write buffer cannot take it.
  assign lsb_go  = from_lsb_ready &&
                   !(from_lsb_wr && (from_lsb_addr[17:16] == IO_HI) && io_buffer_full);
  assign nxt_cnt = cnt_q + 2'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    skip_d        = skip_q;
    asm_d         = asm_q;
    wdata_d       = wdata_q;
    to_if_ok_d    = 1'b0;
    to_if_data_d  = to_if_data_q;
    to_lsb_ok_d   = 1'b0;
    to_lsb_data_d = to_lsb_data_q;
    mem_dout_d    = mem_dout_q;
    mem_a_d       = mem_a_q;
    mem_wr_d      = mem_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (!from_rob_clear) begin
          if (lsb_go) begin
            mem_a_d = from_lsb_addr;
            cnt_d   = 2'd0;
            last_d  = last_idx(from_lsb_len);
            if (from_lsb_wr) begin
              state_d    = ST_LS_WR;
              wdata_d    = from_lsb_data;
              mem_wr_d   = 1'b1;
              mem_dout_d = from_lsb_data[BYTE_W-1:0];
            end else begin
              state_d = ST_LS_RD;
              skip_d  = 1'b1;
              asm_d   = '0;
            end
          end else if (from_if_ready) begin
            state_d = ST_IF_RD;
            mem_a_d = from_if_addr;
            cnt_d   = 2'd0;
            last_d  = 2'd3;
            skip_d  = 1'b1;
            asm_d   = '0;
          end
        end
      end

      ST_IF_RD, ST_LS_RD: begin
        if (from_rob_clear) begin
          state_d  = ST_IDLE;
          mem_a_d  = '0;
          mem_wr_d = 1'b0;
        end else if (skip_q) begin
          // RAM data lags the address by one edge, so the first edge only advances the address.
          skip_d = 1'b0;
          if (last_q != 2'd0) mem_a_d = mem_a_q + ADDR_W'(1);
        end else begin
          asm_d[{cnt_q, 3'b000} +: BYTE_W] = mem_din;
          if (cnt_q == last_q) begin
            state_d = ST_DONE;
            mem_a_d = '0;
            if (state_q == ST_IF_RD) begin
              to_if_ok_d   = 1'b1;
              to_if_data_d = asm_d;
            end else begin
              to_lsb_ok_d   = 1'b1;
              to_lsb_data_d = asm_d;
            end
          end else begin
            cnt_d = nxt_cnt;
            if (({1'b0, cnt_q} + 3'd2) <= {1'b0, last_q}) mem_a_d = mem_a_q + ADDR_W'(1);
          end
        end
      end

      // Committed stores run to completion regardless of a flush.
      ST_LS_WR: begin
        if (cnt_q == last_q) begin
          state_d     = ST_DONE;
          mem_wr_d    = 1'b0;
          mem_a_d     = '0;
          mem_dout_d  = '0;
          to_lsb_ok_d = 1'b1;
        end else begin
          cnt_d      = nxt_cnt;
          mem_a_d    = mem_a_q + ADDR_W'(1);
          mem_dout_d = wdata_q[{nxt_cnt, 3'b000} +: BYTE_W];
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      last_q        <= 2'd0;
      skip_q        <= 1'b0;
      asm_q         <= '0;
      wdata_q       <= '0;
      to_if_ok_q    <= 1'b0;
      to_if_data_q  <= '0;
      to_lsb_ok_q   <= 1'b0;
      to_lsb_data_q <= '0;
      mem_dout_q    <= '0;
      mem_a_q       <= '0;
      mem_wr_q      <= 1'b0;
    end else if (rdy) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      skip_q        <= skip_d;
      asm_q         <= asm_d;
      wdata_q       <= wdata_d;
      to_if_ok_q    <= to_if_ok_d;
      to_if_data_q  <= to_if_data_d;
      to_lsb_ok_q   <= to_lsb_ok_d;
      to_lsb_data_q <= to_lsb_data_d;
      mem_dout_q    <= mem_dout_d;
      mem_a_q       <= mem_a_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

  assign to_if_ok    = to_if_ok_q;
  assign to_if_data  = to_if_data_q;
  assign to_lsb_ok   = to_lsb_ok_q;
  assign to_lsb_data = to_lsb_data_q;
  assign mem_dout    = mem_dout_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected results queued at request time and
// compared when the controller returns ok or drives the bus.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        from_if_ready = 1'b0;
  logic [31:0] from_if_addr = '0;
  logic        to_if_ok;
  logic [31:0] to_if_data;
  logic        from_lsb_ready = 1'b0;
  logic        from_lsb_wr = 1'b0;
  logic [1:0]  from_lsb_len = 2'b00;
  logic [31:0] from_lsb_addr = '0;
  logic [31:0] from_lsb_data = '0;
  logic        to_lsb_ok;
  logic [31:0] to_lsb_data;
  logic        from_rob_clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] if_q[$];
  logic [31:0] lsb_q[$];
  logic [39:0] wr_q[$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .from_if_ready(from_if_ready), .from_if_addr(from_if_addr),
    .to_if_ok(to_if_ok), .to_if_data(to_if_data),
    .from_lsb_ready(from_lsb_ready), .from_lsb_wr(from_lsb_wr),
    .from_lsb_len(from_lsb_len), .from_lsb_addr(from_lsb_addr),
    .from_lsb_data(from_lsb_data), .to_lsb_ok(to_lsb_ok), .to_lsb_data(to_lsb_data),
    .from_rob_clear(from_rob_clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0004: ram_byte = 8'h13;
      32'h0000_0005: ram_byte = 8'h05;
      32'h0000_0100: ram_byte = 8'hAB;
      32'h0000_0101: ram_byte = 8'hCD;
      default:       ram_byte = 8'h00;
    endcase
  endfunction

  // Synchronous RAM read port, stalled together with the rest of the system.
  always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({to_if_ok, to_lsb_ok, mem_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {to_if_ok, to_lsb_ok, mem_wr});
    end
    n_checks++;
    if ({mem_a, mem_dout} !== 40'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", {mem_a, mem_dout});
    end
    n_checks++;
    if ({to_if_data, to_lsb_data} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {to_if_data, to_lsb_data});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch(input logic [31:0] addr, input logic [31:0] exp);
    int got = 0;
    logic [31:0] e;
    if_q.push_back(exp);
    from_if_ready = 1'b1; from_if_addr = addr;
    for (int c = 1; c <= 10 && got == 0; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        n_checks++;
        if (mem_a !== addr + 32'(c - 1)) begin
          n_fail++; $display("FAIL fetch_addr%0d: got %h expected %h", c, mem_a, addr + 32'(c - 1));
        end
      end
      if (to_if_ok) begin
        got = c; from_if_ready = 1'b0;
        e = if_q.pop_front();
        n_checks++;
        if (to_if_data !== e) begin
          n_fail++; $display("FAIL fetch_data: got %h expected %h", to_if_data, e);
        end
        n_checks++;
        if ({mem_wr, mem_a} !== 33'h0) begin
          n_fail++; $display("FAIL fetch_done_bus: got %h expected 0", {mem_wr, mem_a});
        end
      end
    end
    n_checks++;
    if (got != 6) begin
      n_fail++; $display("FAIL fetch_latency: got %0d expected 6", got);
    end
    @(negedge clk);
    n_checks++;
    if (to_if_ok !== 1'b0 || to_if_data !== exp) begin
      n_fail++; $display("FAIL fetch_after: got ok=%b data=%h expected ok=0 data=%h", to_if_ok, to_if_data, exp);
    end
  endtask

  task automatic test_priority();
    int glsb = 0;
    int gif = 0;
    logic [31:0] e;
    lsb_q.push_back(32'h0000_CDAB);
    if_q.push_back(32'h0000_0513);
    from_lsb_ready = 1'b1; from_lsb_wr = 1'b0; from_lsb_len = 2'b01; from_lsb_addr = 32'h100;
    from_if_ready = 1'b1; from_if_addr = 32'h4;
    for (int c = 1; c <= 16 && gif == 0; c++) begin
      @(negedge clk);
      if (to_lsb_ok) begin
        glsb = c; from_lsb_ready = 1'b0;
        e = lsb_q.pop_front();
        n_checks++;
        if (to_lsb_data !== e) begin
          n_fail++; $display("FAIL prio_lsb_data: got %h expected %h", to_lsb_data, e);
        end
      end
      if (to_if_ok) begin
        gif = c; from_if_ready = 1'b0;
        e = if_q.pop_front();
        n_checks++;
        if (to_if_data !== e) begin
          n_fail++; $display("FAIL prio_if_data: got %h expected %h", to_if_data, e);
        end
      end
    end
    n_checks++;
    if (glsb != 4 || gif != 11) begin
      n_fail++; $display("FAIL prio_order: got lsb=%0d if=%0d expected lsb=4 if=11", glsb, gif);
    end
    @(negedge clk);
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] exp, input bit stall);
    int got = 0;
    int n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    int lat = n + 2 + (stall ? 2 : 0);
    logic [31:0] e;
    lsb_q.push_back(exp);
    from_lsb_ready = 1'b1; from_lsb_wr = 1'b0; from_lsb_len = len; from_lsb_addr = addr;
    for (int c = 1; c <= 14 && got == 0; c++) begin
      @(negedge clk);
      if (stall && c == 2) rdy = 1'b0;
      if (stall && c == 3) begin
        n_checks++;
        if (mem_a !== addr + 32'(n > 1 ? 1 : 0)) begin
          n_fail++; $display("FAIL load_stall_addr: got %h expected %h", mem_a, addr + 32'(n > 1 ? 1 : 0));
        end
      end
      if (stall && c == 4) rdy = 1'b1;
      if (to_lsb_ok) begin
        got = c; from_lsb_ready = 1'b0;
        e = lsb_q.pop_front();
        n_checks++;
        if (to_lsb_data !== e) begin
          n_fail++; $display("FAIL load_data: got %h expected %h", to_lsb_data, e);
        end
      end
    end
    n_checks++;
    if (got != lat) begin
      n_fail++; $display("FAIL load_latency: got %0d expected %0d", got, lat);
    end
    @(negedge clk);
    n_checks++;
    if (to_lsb_ok !== 1'b0) begin
      n_fail++; $display("FAIL load_ok_width: got %b expected 0", to_lsb_ok);
    end
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data,
                            input int io_cycles, input int clr_at);
    int got = 0;
    int first = 0;
    int nw = 0;
    int n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    logic [39:0] e;
    for (int k = 0; k < n; k++) wr_q.push_back({addr + 32'(k), data[8*k +: 8]});
    io_buffer_full = (io_cycles > 0);
    from_lsb_ready = 1'b1; from_lsb_wr = 1'b1; from_lsb_len = len;
    from_lsb_addr = addr; from_lsb_data = data;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (mem_wr) begin
        if (first == 0) first = c;
        nw++;
        e = (wr_q.size() > 0) ? wr_q.pop_front() : 40'hXX;
        n_checks++;
        if ({mem_a, mem_dout} !== e) begin
          n_fail++; $display("FAIL store_byte%0d: got %h expected %h", nw, {mem_a, mem_dout}, e);
        end
      end
      if (to_lsb_ok) begin
        got = c; from_lsb_ready = 1'b0; from_lsb_wr = 1'b0;
      end
      if (c == io_cycles) io_buffer_full = 1'b0;
      if (c == clr_at) from_rob_clear = 1'b1;
      if (c == clr_at + 1) from_rob_clear = 1'b0;
    end
    from_rob_clear = 1'b0;
    n_checks++;
    if (first != io_cycles + 1 || nw != n) begin
      n_fail++; $display("FAIL store_writes: got first=%0d count=%0d expected first=%0d count=%0d",
                         first, nw, io_cycles + 1, n);
    end
    n_checks++;
    if (got != io_cycles + 1 + n) begin
      n_fail++; $display("FAIL store_ok: got %0d expected %0d", got, io_cycles + 1 + n);
    end
    wr_q.delete();
    @(negedge clk);
  endtask

  task automatic test_clear();
    bit seen = 0;
    from_if_ready = 1'b1; from_if_addr = 32'h4;
    @(negedge clk);
    @(negedge clk);
    from_rob_clear = 1'b1; from_if_ready = 1'b0;
    @(negedge clk);
    from_rob_clear = 1'b0;
    n_checks++;
    if ({mem_wr, mem_a} !== 33'h0) begin
      n_fail++; $display("FAIL clear_bus: got %h expected 0", {mem_wr, mem_a});
    end
    for (int c = 0; c < 8; c++) begin
      if (to_if_ok) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL clear_no_ok: got ok pulse expected none");
    end
  endtask

  task automatic test_reset_mid_store();
    from_lsb_ready = 1'b1; from_lsb_wr = 1'b1; from_lsb_len = 2'b10;
    from_lsb_addr = 32'h300; from_lsb_data = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h301) begin
      n_fail++; $display("FAIL rst_store_active: got wr=%b a=%h expected wr=1 a=00000301", mem_wr, mem_a);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({to_if_ok, to_lsb_ok, mem_wr, mem_a, mem_dout, to_lsb_data} !== 75'h0) begin
      n_fail++; $display("FAIL rst_async: got %h expected 0",
                         {to_if_ok, to_lsb_ok, mem_wr, mem_a, mem_dout, to_lsb_data});
    end
    from_lsb_ready = 1'b0; from_lsb_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_wr !== 1'b0 || to_lsb_ok !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got wr=%b ok=%b expected 0 0", mem_wr, to_lsb_ok);
    end
  endtask

  initial begin
    test_reset();
    test_fetch(32'h4, 32'h0000_0513);
    test_priority();
    test_store(32'h200, 2'b10, 32'hDEAD_BEEF, 0, 0);
    test_store(32'h3_0000, 2'b00, 32'h0000_005A, 3, 0);
    test_clear();
    test_fetch(32'h4, 32'h0000_0513);
    test_load(32'h100, 2'b01, 32'h0000_CDAB, 1'b0);
    test_load(32'h101, 2'b00, 32'h0000_00CD, 1'b0);
    test_load(32'h4, 2'b11, 32'h0000_0513, 1'b1);
    test_store(32'h210, 2'b01, 32'h0000_1234, 0, 2);
    test_reset_mid_store();
    test_fetch(32'h4, 32'h0000_0513);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
